// File: rtl/mem_port_arbiter.sv
// Multi-channel memory port arbiter: fixed-select or round-robin ownership of a single memory port.
// Optional macro ARB_BURST_LIMIT_EN adds a beat counter that forces round-robin rotation.
module mem_port_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned AW        = 26,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [$clog2(N_CH)-1:0] sel_ch,
    input  logic [N_CH-1:0]         ch_wvalid,
    input  logic [N_CH-1:0]         ch_rvalid,
    output logic [N_CH-1:0]         ch_wready,
    output logic [N_CH-1:0]         ch_rready,
    input  logic [N_CH*AW-1:0]      ch_waddr,
    input  logic [N_CH*AW-1:0]      ch_raddr,
    input  logic [N_CH*DW-1:0]      ch_wdata,
    output logic [N_CH*DW-1:0]      ch_rdata,
    output logic                    wvalid,
    output logic                    rvalid,
    output logic [AW-1:0]           waddr,
    output logic [AW-1:0]           raddr,
    output logic [DW-1:0]           wdata,
    input  logic                    wready,
    input  logic                    rready,
    input  logic [DW-1:0]           rdata,
    output logic [N_CH-1:0]         grant,
    output logic                    busy
);
    localparam int unsigned SELW = $clog2(N_CH);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic [SELW-1:0] last_q, last_d;
    logic            mode_q;
    logic [N_CH-1:0] req, fix_pick;
    logic            owner_req;

    assign req       = ch_wvalid | ch_rvalid;
    assign owner_req = |(req & grant_q);
    assign grant     = grant_q;
    assign busy      = |grant_q;

    // First requester strictly after p, ascending and wrapping (p itself is checked last).
    function automatic logic [N_CH-1:0] rr_pick(input logic [N_CH-1:0] r, input logic [SELW-1:0] p);
        logic [2*N_CH-1:0] dbl;
        logic [N_CH-1:0]   rot, g;
        logic              found;
        int unsigned       first, pos;
        dbl   = {r, r} >> (32'(p) + 1);
        rot   = dbl[N_CH-1:0];
        found = 1'b0;
        first = 0;
        for (int unsigned j = 0; j < N_CH; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                first = j;
            end
        end
        pos = (32'(p) + 1 + first) % N_CH;
        g   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (found && i == pos) g[i] = 1'b1;
        end
        return g;
    endfunction

    always_comb begin
        fix_pick = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel_ch == SELW'(i)) fix_pick[i] = req[i];
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam int unsigned CW = $clog2(BURST_MAX + 1);
    logic [CW-1:0] cnt_q, cnt_d, cnt_sum;
    logic          beat, cnt_wrap;

    assign beat     = (wvalid & wready) | (rvalid & rready);
    assign cnt_sum  = cnt_q + CW'(beat);
    assign cnt_wrap = (cnt_sum == CW'(BURST_MAX));
    assign cnt_d    = (grant_d != grant_q || cnt_wrap) ? '0 : cnt_sum;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    // While owning, last_q always equals the owner index, so it doubles as the search origin.
    always_comb begin
        grant_d = grant_q;
        if (state_q == S_IDLE)
            grant_d = mode ? rr_pick(req, last_q) : fix_pick;
        else if (mode != mode_q)
            grant_d = |((mode ? req : fix_pick) & grant_q) ? grant_q : '0;
        else if (!mode)
            grant_d = fix_pick;
        else if (!owner_req)
            grant_d = rr_pick(req, last_q);
`ifdef ARB_BURST_LIMIT_EN
        else if (cnt_wrap && |(req & ~grant_q))
            grant_d = rr_pick(req & ~grant_q, last_q);
`endif
        state_d = |grant_d ? S_OWN : S_IDLE;
        last_d  = last_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (grant_d[i]) last_d = SELW'(i);
        end
    end

    always_comb begin
        wvalid    = 1'b0;
        rvalid    = 1'b0;
        waddr     = '0;
        raddr     = '0;
        wdata     = '0;
        ch_wready = '0;
        ch_rready = '0;
        ch_rdata  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_wready[i] = grant_q[i] & wready;
            ch_rready[i] = grant_q[i] & rready;
            if (grant_q[i]) begin
                ch_rdata[i*DW +: DW] = rdata;
                wvalid = ch_wvalid[i];
                rvalid = ch_rvalid[i];
                waddr  = ch_waddr[i*AW +: AW];
                raddr  = ch_raddr[i*AW +: AW];
                wdata  = ch_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= SELW'(N_CH - 1);
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            mode_q  <= mode;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic against an owner-level model.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int BM = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, mode;
    logic [1:0]      sel_ch;
    logic [N-1:0]    ch_wvalid, ch_rvalid, ch_wready, ch_rready, grant;
    logic [N*AW-1:0] ch_waddr, ch_raddr;
    logic [N*DW-1:0] ch_wdata, ch_rdata;
    logic            wvalid, rvalid, wready, rready, busy;
    logic [AW-1:0]   waddr, raddr;
    logic [DW-1:0]   wdata, rdata;

    // Second instance with 5 channels so that an out-of-range sel_ch is representable.
    logic [2:0]  sel5;
    logic [4:0]  ch_wv5, ch_rv5, ch_wr5, ch_rr5, grant5;
    logic [39:0] ch_wa5, ch_ra5, ch_wd5, ch_rd5;
    logic        wv5, rv5, busy5;
    logic [7:0]  wa5, ra5, wd5;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int       m_owner = -1;
    int       m_last  = N - 1;
    int       m_cnt   = 0;
    logic     m_mode_prev = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_CH(N), .AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel_ch(sel_ch),
        .ch_wvalid(ch_wvalid), .ch_rvalid(ch_rvalid), .ch_wready(ch_wready), .ch_rready(ch_rready),
        .ch_waddr(ch_waddr), .ch_raddr(ch_raddr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata),
        .wvalid(wvalid), .rvalid(rvalid), .waddr(waddr), .raddr(raddr), .wdata(wdata),
        .wready(wready), .rready(rready), .rdata(rdata), .grant(grant), .busy(busy)
    );

    mem_port_arbiter #(.N_CH(5), .AW(8), .DW(8), .BURST_MAX(BM)) u5 (
        .clk(clk), .rst(rst), .mode(1'b0), .sel_ch(sel5),
        .ch_wvalid(ch_wv5), .ch_rvalid(ch_rv5), .ch_wready(ch_wr5), .ch_rready(ch_rr5),
        .ch_waddr(ch_wa5), .ch_raddr(ch_ra5), .ch_wdata(ch_wd5), .ch_rdata(ch_rd5),
        .wvalid(wv5), .rvalid(rv5), .waddr(wa5), .raddr(ra5), .wdata(wd5),
        .wready(1'b0), .rready(1'b0), .rdata(8'h00), .grant(grant5), .busy(busy5)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] v;
        v = '0;
        if (o >= 0) v[o] = 1'b1;
        return v;
    endfunction

    function automatic int rr_next(input int from, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic int fixed_pick(input logic [N-1:0] r, input logic [1:0] s);
        if (int'(s) < N && r[s]) return int'(s);
        return -1;
    endfunction

    // Owner-level reference: who owns the port after each edge.
    always @(posedge clk) begin : model
        int nxt, beats, hs;
        logic [N-1:0] rq, others;
        rq = ch_wvalid | ch_rvalid;
        if (rst) begin
            m_owner     <= -1;
            m_last      <= N - 1;
            m_cnt       <= 0;
            m_mode_prev <= 1'b0;
        end else begin
            hs = 0;
            if (m_owner >= 0 && ((ch_wvalid[m_owner] && wready) || (ch_rvalid[m_owner] && rready))) hs = 1;
            beats  = m_cnt + hs;
            others = rq & ~onehot(m_owner);
            if (m_owner < 0)
                nxt = mode ? rr_next(m_last, rq) : fixed_pick(rq, sel_ch);
            else if (mode != m_mode_prev)
                nxt = (mode ? rq[m_owner] : (fixed_pick(rq, sel_ch) == m_owner)) ? m_owner : -1;
            else if (!mode)
                nxt = fixed_pick(rq, sel_ch);
            else if (!rq[m_owner])
                nxt = rr_next(m_owner, rq);
            else if (LIM && beats == BM && others != '0)
                nxt = rr_next(m_owner, others);
            else
                nxt = m_owner;
            m_owner <= nxt;
            if (nxt >= 0) m_last <= nxt;
            m_cnt       <= (nxt != m_owner || beats == BM) ? 0 : beats;
            m_mode_prev <= mode;
        end
    end

    always @(negedge clk) begin : compare
        logic [N*DW-1:0] erd;
        logic [N-1:0]    eg;
        if (cmp_en) begin
            eg = onehot(m_owner);
            erd = '0;
            if (m_owner >= 0) erd[m_owner*DW +: DW] = rdata;
            chk("grant", grant, eg);
            chk("busy", busy, (m_owner >= 0));
            chk("ch_wready", ch_wready, wready ? eg : '0);
            chk("ch_rready", ch_rready, rready ? eg : '0);
            chk("ch_rdata", ch_rdata, erd);
            if (m_owner >= 0) begin
                chk("mem_write", {wvalid, waddr, wdata},
                    {ch_wvalid[m_owner], ch_waddr[m_owner*AW +: AW], ch_wdata[m_owner*DW +: DW]});
                chk("mem_read", {rvalid, raddr}, {ch_rvalid[m_owner], ch_raddr[m_owner*AW +: AW]});
            end else begin
                chk("mem_write_idle", {wvalid, waddr, wdata}, '0);
                chk("mem_read_idle", {rvalid, raddr}, '0);
            end
        end
    end

    initial begin
        rst = 1'b1; mode = 1'b0; sel_ch = 2'd0;
        ch_wvalid = '0; ch_rvalid = '0; ch_waddr = '0; ch_raddr = '0; ch_wdata = '0;
        wready = 1'b0; rready = 1'b0; rdata = '0;
        sel5 = 3'd5; ch_wv5 = '1; ch_rv5 = '0; ch_wa5 = '0; ch_ra5 = '0; ch_wd5 = '0;

        step();
        cmp_en = 1'b1;
        chk("reset_grant", grant, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valids", {wvalid, rvalid}, 2'b00);

        // Round-robin start and burst rotation.
        rst = 1'b0; mode = 1'b1; ch_wvalid = 4'b0101;
        step();
        chk("rr_first_grant", grant, 4'b0001);
        wready = 1'b1;
        repeat (3) step();
        chk("burst_before_limit", grant, 4'b0001);
        step();
        chk("burst_rotate", grant, LIM ? 4'b0100 : 4'b0001);
        ch_wvalid = '0; wready = 1'b0;
        step();
        chk("release_idle", grant, 4'b0000);

        // Lone requester keeps the grant across counter wraps.
        ch_rvalid = 4'b1000; rready = 1'b1;
        step();
        for (int b = 0; b < 10; b++) begin
            chk("lone_owner", {busy, grant}, 5'b1_1000);
            step();
        end

        // Mode change to fixed with a non-matching owner drops to idle first.
        ch_rvalid = '0; rready = 1'b0; mode = 1'b0; sel_ch = 2'd1;
        ch_wvalid = 4'b0010;
        ch_waddr[1*AW +: AW] = 26'h100;
        ch_wdata[1*DW +: DW] = 32'hDEADBEEF;
        step();
        chk("mode_change_idle", grant, 4'b0000);
        step();
        chk("fixed_grant", grant, 4'b0010);
        wready = 1'b1;
        #1;
        chk("fixed_waddr", waddr, 26'h100);
        chk("fixed_wdata", wdata, 32'hDEADBEEF);
        chk("fixed_wready", ch_wready, 4'b0010);
        ch_rvalid = 4'b0010; rready = 1'b1; rdata = 32'h1234;
        #1;
        chk("read_route", ch_rdata, {32'h0, 32'h0, 32'h1234, 32'h0});
        step();

        // Mid-burst reset.
        mode = 1'b1; ch_wvalid = 4'b0100; ch_rvalid = '0; rready = 1'b0; rdata = '0;
        step();
        chk("rr_mode_drop", grant, 4'b0000);
        step();
        chk("rr_ch2", grant, 4'b0100);
        ch_wvalid = 4'b1110;
        repeat (2) step();
        chk("ch2_held", grant, 4'b0100);
        rst = 1'b1;
        step();
        chk("midreset_grant", grant, 4'b0000);
        chk("midreset_valids", {wvalid, rvalid, ch_wready, ch_rready}, 10'b0);
        rst = 1'b0;
        step();
        chk("post_reset_lowest", grant, 4'b0010);

        // Out-of-range fixed selection on the 5-channel instance.
        chk("oor5_grant", {busy5, grant5}, 6'b0);
        sel5 = 3'd7;
        step();
        chk("oor7_grant", {busy5, grant5}, 6'b0);
        sel5 = 3'd4;
        step();
        chk("sel4_grant", {busy5, grant5}, 6'b1_10000);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) sel_ch = 2'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) ch_wvalid[i] = ~ch_wvalid[i];
                if ($urandom_range(0, 5) == 0) ch_rvalid[i] = ~ch_rvalid[i];
                ch_waddr[i*AW +: AW] = AW'($urandom);
                ch_raddr[i*AW +: AW] = AW'($urandom);
                ch_wdata[i*DW +: DW] = $urandom;
            end
            wready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
            rdata  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
